// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Brief   : Single-cycle data-port responder: word RAM plus STATUS, TXDATA
//           (byte FIFO to a console handshake) and CYCLES registers.
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] c_addr_status = 32'h0000_0400;
    localparam logic [31:0] c_addr_txdata = 32'h0000_0401;
    localparam logic [31:0] c_addr_cycles = 32'h0000_0402;
    localparam logic [31:0] c_ram_words   = 32'(DEPTH);
    localparam logic [PW:0] c_fifo_full   = (PW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_ram  [0:DEPTH-1];
    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_hold;
    logic [31:0]   r_cycles;

    logic          w_ram_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic [7:0]    w_count8;

    assign w_ram_sel = (Addr < c_ram_words);
    assign w_ram_idx = Addr[AW-1:0];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_fifo_full);
    assign w_pop     = !w_empty && tx_ready;
    assign w_push    = MemWrite && (Addr == c_addr_txdata);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_count8  = 8'(r_count);

    // RAM and FIFO storage are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (MemWrite && w_ram_sel) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_tail] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_hold     <= 8'h00;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
                r_hold <= r_fifo[r_head];
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + (PW + 1)'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - (PW + 1)'(1);
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end else if (MemWrite && (Addr == c_addr_status)) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles <= 32'h0;
        end else if (MemWrite && (Addr == c_addr_cycles)) begin
            r_cycles <= WriteData;
        end else begin
            r_cycles <= r_cycles + 32'h1;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (w_ram_sel) begin
            ReadData = r_ram[w_ram_idx];
        end else if (Addr == c_addr_status) begin
            ReadData = {16'h0, w_count8, 5'h0, r_overflow, w_full, w_empty};
        end else if (Addr == c_addr_cycles) begin
            ReadData = r_cycles;
        end
    end

    // Once empty, tx_data keeps showing the byte most recently popped.
    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? r_hold : r_fifo[r_head];

endmodule
`default_nettype wire
